riscv_ifetch_buf: RTL and testbench

//  Parametrised instruction-fetch buffer that succeeds the combinational fetch stage.

---
 rtl/riscv_ifetch_buf.sv | 149 ++++++++++++++
 tb/tb_riscv_ifetch_buf.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ifetch_buf.sv
// riscv_ifetch_buf: instruction-fetch buffer between the fetch stage and if_id.
// Owns the PC, issues pipelined req/gnt requests to the instruction ROM, queues
// up to DEPTH in-order responses and delivers {inst, addr} over valid/ready.
// A jump flushes the queue and drops any responses still in flight.
// Optional feature macro: RISCV_IFB_BYPASS_EN (forward rom_rdata_i straight to
// inst_o when the response fills the head slot, saving one cycle of latency).
module riscv_ifetch_buf #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            rom_req_o,
    output logic [XLEN-1:0] rom_addr_o,
    input  logic            rom_gnt_i,
    input  logic            rom_rvalid_i,
    input  logic [31:0]     rom_rdata_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_addr_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [XLEN-1:0]  pc;
    logic [PW-1:0]    alloc_ptr;
    logic [PW-1:0]    fill_ptr;
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    drop_cnt;

    logic [XLEN-1:0]  slot_addr [DEPTH];
    logic [31:0]      slot_data [DEPTH];
    logic [DEPTH-1:0] slot_filled;

    logic [AW-1:0]    alloc_idx;
    logic [AW-1:0]    fill_idx;
    logic [AW-1:0]    head_idx;
    logic [PW-1:0]    alloc_cnt;
    logic [PW-1:0]    unfilled_cnt;
    logic [PW:0]      credit_used;
    logic [PW:0]      outstanding;
    logic [PW:0]      drop_on_jump;
    logic             resp_drop;
    logic             resp_take;
    logic             head_filled;
    logic             bypass_hit;
    logic             bypass_pop;
    logic             fire;
    logic             pop;

    // Queue bookkeeping, request/credit logic and output selection.
    always_comb begin
        alloc_idx    = alloc_ptr[AW-1:0];
        fill_idx     = fill_ptr[AW-1:0];
        head_idx     = head_ptr[AW-1:0];
        alloc_cnt    = alloc_ptr - head_ptr;
        unfilled_cnt = alloc_ptr - fill_ptr;
        credit_used  = {1'b0, alloc_cnt} + {1'b0, drop_cnt};

        // Responses still owed by the ROM after a flush: old drops plus every
        // unfilled slot, less the one arriving in the jump cycle itself.
        outstanding  = {1'b0, drop_cnt} + {1'b0, unfilled_cnt};
        drop_on_jump = outstanding;
        if (rom_rvalid_i && (outstanding != '0)) begin
            drop_on_jump = outstanding - (PW+1)'(1);
        end

        resp_drop   = rom_rvalid_i && !jump_en_i && (drop_cnt != '0);
        resp_take   = rom_rvalid_i && !jump_en_i && (drop_cnt == '0) && (unfilled_cnt != '0);
        head_filled = slot_filled[head_idx] && (alloc_cnt != '0);

`ifdef RISCV_IFB_BYPASS_EN
        // fill == head with a live response means the head slot is being filled now.
        bypass_hit = resp_take && (fill_ptr == head_ptr);
`else
        bypass_hit = 1'b0;
`endif

        rom_req_o    = !rst && !jump_en_i && (credit_used < DEPTH_W);
        rom_addr_o   = pc;
        fire         = rom_req_o && rom_gnt_i;
        inst_valid_o = !rst && !jump_en_i && (head_filled || bypass_hit);
        pop          = inst_valid_o && inst_ready_i;
        bypass_pop   = bypass_hit && pop;

        inst_o      = NOP;
        inst_addr_o = '0;
        if (inst_valid_o) begin
            inst_addr_o = slot_addr[head_idx];
            inst_o      = bypass_hit ? rom_rdata_i : slot_data[head_idx];
        end
    end

    // PC, queue pointers and drop counter; a jump overrides issue, fill and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
        end else if (jump_en_i) begin
            pc       <= jump_addr_i & ~XLEN'(3);
            head_ptr <= alloc_ptr;
            fill_ptr <= alloc_ptr;
            drop_cnt <= drop_on_jump[PW-1:0];
        end else begin
            if (fire) begin
                alloc_ptr <= alloc_ptr + PW'(1);
                pc        <= pc + XLEN'(4);
            end
            if (resp_take) begin
                fill_ptr <= fill_ptr + PW'(1);
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - PW'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
        end
    end

    // Slot storage: address captured on grant, data and filled flag on response.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_filled <= '0;
        end else if (!jump_en_i) begin
            if (fire) begin
                slot_addr[alloc_idx]   <= pc;
                slot_filled[alloc_idx] <= 1'b0;
            end
            if (resp_take) begin
                slot_data[fill_idx] <= rom_rdata_i;
                if (!bypass_pop) begin
                    slot_filled[fill_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_ifetch_buf.sv
// Testbench for riscv_ifetch_buf: randomized ROM/consumer behaviour checked
// against a transaction-level model (queues of granted fetches and of ROM
// responses in flight), plus directed scenarios for latency, hold, jumps, wrap.
module tb_riscv_ifetch_buf;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef RISCV_IFB_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    always #5 clk = ~clk;

    riscv_ifetch_buf #(
        .XLEN    (32),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .rom_req_o   (rom_req_o),
        .rom_addr_o  (rom_addr_o),
        .rom_gnt_i   (rom_gnt_i),
        .rom_rvalid_i(rom_rvalid_i),
        .rom_rdata_i (rom_rdata_i),
        .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        arrived;
    } fetch_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          gen;
    } rom_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
    } ev_t;

    fetch_t      stq[$];
    rom_t        romq[$];
    ev_t         fire_log[$];
    ev_t         pop_log[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          cur_gen = 0;
    int          last_due = 0;
    int          gnt_pct = 100;
    int          rdy_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] m_pc;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F0F};
    endfunction

    // One clock cycle: drive ROM/consumer, compare DUT against the model, advance model.
    task automatic tick(input logic jmp, input logic [31:0] jaddr);
        int          stale;
        int          l;
        int          due;
        logic        resp;
        logic        exp_req;
        logic        exp_valid;
        logic        fire;
        logic        pop;
        logic [31:0] exp_inst;
        logic [31:0] exp_iaddr;
        rom_t        r;

        rom_gnt_i    = ($urandom_range(99) < gnt_pct);
        inst_ready_i = ($urandom_range(99) < rdy_pct);
        jump_en_i    = jmp;
        jump_addr_i  = jaddr;
        resp         = (romq.size() > 0) && (romq[0].due <= cyc);
        rom_rvalid_i = resp;
        rom_rdata_i  = resp ? rom_word(romq[0].addr) : $urandom;
        #1;

        stale = 0;
        foreach (romq[i]) if (romq[i].gen != cur_gen) stale++;
        exp_req   = !jmp && ((stq.size() + stale) < DEPTH);
        exp_valid = 1'b0;
        if (!jmp && stq.size() > 0) begin
            if (stq[0].arrived) exp_valid = 1'b1;
`ifdef RISCV_IFB_BYPASS_EN
            else if (resp && romq[0].gen == cur_gen) exp_valid = 1'b1;
`endif
        end
        exp_iaddr = exp_valid ? stq[0].addr : 32'h0;
        exp_inst  = exp_valid ? rom_word(stq[0].addr) : NOP;

        checks++;
        if (rom_req_o !== exp_req) begin
            failures++;
            $display("FAIL rom_req cyc=%0d got=%b exp=%b", cyc, rom_req_o, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (rom_addr_o !== m_pc) begin
                failures++;
                $display("FAIL rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr_o, m_pc);
            end
        end
        checks++;
        if (inst_valid_o !== exp_valid) begin
            failures++;
            $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_o, exp_valid);
        end
        checks++;
        if (inst_addr_o !== exp_iaddr) begin
            failures++;
            $display("FAIL inst_addr cyc=%0d got=%h exp=%h", cyc, inst_addr_o, exp_iaddr);
        end
        checks++;
        if (inst_o !== exp_inst) begin
            failures++;
            $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, inst_o, exp_inst);
        end

        fire = exp_req && rom_gnt_i;
        pop  = exp_valid && inst_ready_i;

        @(posedge clk);
        if (resp) begin
            r = romq.pop_front();
            if (!jmp && r.gen == cur_gen) begin
                for (int i = 0; i < stq.size(); i++) begin
                    if (!stq[i].arrived) begin
                        stq[i].arrived = 1'b1;
                        break;
                    end
                end
            end
        end
        if (jmp) begin
            cur_gen++;
            stq.delete();
            m_pc = {jaddr[31:2], 2'b00};
        end else begin
            if (pop) begin
                pop_log.push_back('{cyc, stq[0].addr});
                void'(stq.pop_front());
            end
            if (fire) begin
                l   = int'($urandom_range(lat_max, lat_min));
                due = cyc + l;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                romq.push_back('{m_pc, due, cur_gen});
                stq.push_back('{m_pc, 1'b0});
                fire_log.push_back('{cyc, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_logs();
        fire_log.delete();
        pop_log.delete();
    endtask

    // Reset for n cycles; outputs must be idle while rst is high.
    task automatic test_reset(input int n);
        rst          = 1'b1;
        jump_en_i    = 1'b0;
        jump_addr_i  = 32'h0;
        rom_gnt_i    = 1'b1;
        inst_ready_i = 1'b1;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = 32'h0;
        #1;
        checks++;
        if (rom_req_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got=%b exp=0", rom_req_o);
        end
        checks++;
        if (inst_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", inst_valid_o);
        end
        checks++;
        if (inst_o !== NOP) begin
            failures++;
            $display("FAIL reset_inst got=%h exp=%h", inst_o, NOP);
        end
        checks++;
        if (inst_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_iaddr got=%h exp=0", inst_addr_o);
        end
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        stq.delete();
        romq.delete();
        cur_gen++;
        last_due = cyc;
        m_pc = 32'h0;
        clear_logs();
    endtask

    task automatic test_stream();
        test_reset(2);
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (10) tick(1'b0, 32'h0);
        checks++;
        if (fire_log.size() < 8 || pop_log.size() < 6) begin
            failures++;
            $display("FAIL stream_count fires=%0d pops=%0d exp>=8,>=6", fire_log.size(), pop_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (pop_log[i].addr !== 32'(4 * i) || pop_log[i].cyc !== fire_log[0].cyc + EXP_LAT + i) begin
                    failures++;
                    $display("FAIL stream_pop%0d got=%h@%0d exp=%h@%0d", i, pop_log[i].addr,
                             pop_log[i].cyc, 32'(4 * i), fire_log[0].cyc + EXP_LAT + i);
                end
            end
        end
    endtask

    task automatic test_hold();
        test_reset(1);
        gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
        repeat (10) tick(1'b0, 32'h0);
        checks++;
        if (fire_log.size() !== DEPTH) begin
            failures++;
            $display("FAIL hold_grants got=%0d exp=%0d", fire_log.size(), DEPTH);
        end
        gnt_pct = 0; rdy_pct = 100;
        repeat (6) tick(1'b0, 32'h0);
        checks++;
        if (pop_log.size() !== DEPTH) begin
            failures++;
            $display("FAIL hold_pops got=%0d exp=%0d", pop_log.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (pop_log[i].addr !== 32'(4 * i)) begin
                    failures++;
                    $display("FAIL hold_order%0d got=%h exp=%h", i, pop_log[i].addr, 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_jump_inflight();
        test_reset(1);
        gnt_pct = 100; rdy_pct = 100; lat_min = 4; lat_max = 4;
        repeat (3) tick(1'b0, 32'h0);
        clear_logs();
        tick(1'b1, 32'h103);
        repeat (14) tick(1'b0, 32'h0);
        checks++;
        if (fire_log.size() == 0 || fire_log[0].addr !== 32'h100) begin
            failures++;
            $display("FAIL jump_req_addr got=%h exp=00000100", fire_log.size() ? fire_log[0].addr : 32'hx);
        end
        checks++;
        if (pop_log.size() == 0 || pop_log[0].addr !== 32'h100) begin
            failures++;
            $display("FAIL jump_first_inst got=%h exp=00000100", pop_log.size() ? pop_log[0].addr : 32'hx);
        end
    endtask

    task automatic test_jump_rvalid_pop();
        test_reset(1);
        gnt_pct = 100; rdy_pct = 100; lat_min = 2; lat_max = 2;
        repeat (4) tick(1'b0, 32'h0);
        clear_logs();
        tick(1'b1, 32'h200);
        checks++;
        if (pop_log.size() !== 0) begin
            failures++;
            $display("FAIL jrp_no_pop got=%0d exp=0", pop_log.size());
        end
        jump_en_i = 1'b0;
        #1;
        checks++;
        if (inst_valid_o !== 1'b0 || rom_req_o !== 1'b1) begin
            failures++;
            $display("FAIL jrp_after valid=%b req=%b exp valid=0 req=1", inst_valid_o, rom_req_o);
        end
        repeat (12) tick(1'b0, 32'h0);
        checks++;
        if (pop_log.size() == 0 || pop_log[0].addr !== 32'h200) begin
            failures++;
            $display("FAIL jrp_first_inst got=%h exp=00000200", pop_log.size() ? pop_log[0].addr : 32'hx);
        end
    endtask

    task automatic test_wrap();
        test_reset(1);
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        tick(1'b1, 32'hFFFF_FFFE);
        clear_logs();
        repeat (8) tick(1'b0, 32'h0);
        checks++;
        if (fire_log.size() < 2 || fire_log[0].addr !== 32'hFFFF_FFFC || fire_log[1].addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_req n=%0d exp FFFFFFFC,00000000", fire_log.size());
        end
        checks++;
        if (pop_log.size() < 2 || pop_log[0].addr !== 32'hFFFF_FFFC || pop_log[1].addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_inst n=%0d exp FFFFFFFC,00000000", pop_log.size());
        end
    endtask

    task automatic test_latency();
        test_reset(1);
        rdy_pct = 100; lat_min = 1; lat_max = 1;
        gnt_pct = 100;
        tick(1'b0, 32'h0);
        gnt_pct = 0;
        repeat (5) tick(1'b0, 32'h0);
        checks++;
        if (fire_log.size() != 1 || pop_log.size() != 1 ||
            pop_log[0].cyc - fire_log[0].cyc !== EXP_LAT) begin
            failures++;
            $display("FAIL latency fires=%0d pops=%0d exp_lat=%0d", fire_log.size(), pop_log.size(), EXP_LAT);
        end
    endtask

    task automatic test_random();
        test_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                gnt_pct = int'($urandom_range(100, 20));
                rdy_pct = int'($urandom_range(100, 10));
                lat_min = int'($urandom_range(3, 1));
                lat_max = lat_min + int'($urandom_range(3, 0));
            end
            if ($urandom_range(399) == 0) test_reset(1);
            if ($urandom_range(99) < 4) tick(1'b1, $urandom);
            else                        tick(1'b0, 32'h0);
        end
    endtask

    initial begin
        test_reset(2);
        test_stream();
        test_hold();
        test_jump_inflight();
        test_jump_rvalid_pop();
        test_wrap();
        test_latency();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
